// File: rtl/mat_stream_loader.sv
// mat_stream_loader: deframes a stream of 2*N*N signed elements into a matrix pair with framing-error detection
module mat_stream_loader #(
  parameter int W_IN = 8,
  parameter int N    = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cen,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic [W_IN-1:0]        s_data,
  input  logic                   s_last,
  output logic signed [W_IN-1:0] matrix_1 [N][N],
  output logic signed [W_IN-1:0] matrix_2 [N][N],
  output logic                   valid_out,
  output logic                   err,
  output logic [15:0]            frame_cnt
);
  localparam int NN = N * N;
  localparam int CW = $clog2(2 * NN);
  localparam logic [CW-1:0] LAST = CW'(2 * NN - 1);
  localparam logic [CW-1:0] HALF = CW'(NN);
  typedef enum logic [1:0] {LOAD_A, LOAD_B, FLUSH} state_t;
  state_t          state;
  logic [CW-1:0]   count;
  logic [W_IN-1:0] shadow [2*NN];
  logic [W_IN-1:0] nxt    [2*NN];
  logic            acc;
  assign s_ready = cen & ~rst;
  assign acc     = s_valid & s_ready;
  // Shadow image including the beat being accepted, so the final element lands in the copy directly
  always_comb begin
    for (int i = 0; i < 2 * NN; i++)
      nxt[i] = (CW'(i) == count) ? s_data : shadow[i];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= LOAD_A;
      count     <= '0;
      valid_out <= 1'b0;
      err       <= 1'b0;
      frame_cnt <= '0;
      shadow    <= '{default: '0};
      matrix_1  <= '{default: '0};
      matrix_2  <= '{default: '0};
    end else if (cen) begin
      valid_out <= 1'b0;
      if (acc) begin
        if (state == FLUSH) begin
          if (s_last) begin
            count <= '0;
            state <= LOAD_A;
          end
        end else begin
          shadow[count] <= s_data;
          if (count == LAST) begin
            count <= '0;
            if (s_last) begin
              for (int r = 0; r < N; r++)
                for (int c = 0; c < N; c++) begin
                  matrix_1[r][c] <= nxt[r*N+c];
                  matrix_2[r][c] <= nxt[NN+r*N+c];
                end
              valid_out <= 1'b1;
              frame_cnt <= frame_cnt + 16'd1;
              state     <= LOAD_A;
            end else begin
              err   <= 1'b1;
              state <= FLUSH;
            end
          end else if (s_last) begin
            err   <= 1'b1;
            count <= '0;
            state <= LOAD_A;
          end else begin
            count <= count + 1'b1;
            state <= (count + 1'b1 >= HALF) ? LOAD_B : LOAD_A;
          end
        end
      end
    end
  end
endmodule

// File: doc/mat_stream_loader.md
MAT_STREAM_LOADER -- requirements
Module: mat_stream_loader

Interface
REQ-001 SHALL have parameter W_IN, default 8: element width, signed two's complement.
REQ-002 SHALL have parameter N, default 2: matrix dimension (N x N); N >= 2.
REQ-003 SHALL have port clk, input, 1: single clock; all logic on posedge.
REQ-004 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port cen, input, 1: clock enable; no state changes when low.
REQ-006 SHALL have port s_valid, input, 1: stream element valid.
REQ-007 SHALL have port s_ready, output, 1: stream element accepted when s_valid & s_ready.
REQ-008 SHALL have port s_data, input, W_IN: signed element.
REQ-009 SHALL have port s_last, input, 1: marks final element of a frame.
REQ-010 SHALL have port matrix_1, output, signed W_IN, [N][N]: loaded matrix A.
REQ-011 SHALL have port matrix_2, output, signed W_IN, [N][N]: loaded matrix B.
REQ-012 SHALL have port valid_out, output, 1: new matrix pair present, feeds the multiplier's valid_in.
REQ-013 SHALL have port err, output, 1: sticky framing-error flag.
REQ-014 SHALL have port frame_cnt, output, 16: count of frames successfully emitted.

Function
REQ-015 SHALL define a frame as 2*N*N elements: matrix_1 row-major (elements 0..N*N-1), then matrix_2 row-major (elements N*N..2*N*N-1).
REQ-016 SHALL assert s_ready = cen & ~rst in states LOAD_A, LOAD_B and FLUSH; never deassert on backpressure otherwise.
REQ-017 SHALL accept a beat only on a posedge with cen=1, s_valid=1, s_ready=1; beats with cen=0 are not accepted and nothing advances.
REQ-018 SHALL write accepted elements into a shadow buffer indexed by a beat counter of width $clog2(2*N*N), counting 0..2*N*N-1.
REQ-019 SHALL implement FSM states LOAD_A (count < N*N), LOAD_B (count >= N*N), FLUSH.
REQ-020 SHALL transition LOAD_A -> LOAD_B on accepting element N*N-1 with s_last=0.
REQ-021 SHALL, on accepting element 2*N*N-1 with s_last=1, copy the full shadow buffer into matrix_1/matrix_2, set valid_out=1 on the next cycle, increment frame_cnt (wrapping 0xFFFF -> 0), reset count to 0, go to LOAD_A.
REQ-022 SHALL hold matrix_1/matrix_2 stable between completed frames; partial or errored frames never alter them.
REQ-023 SHALL make valid_out a one-beat pulse: cleared at the next posedge with cen=1; held while cen=0.
REQ-024 SHALL allow a new frame's element 0 to be accepted in the same cycle valid_out is high (zero-bubble back-to-back frames).
REQ-025 SHALL, on accepting s_last=1 at any count < 2*N*N-1 (early last), set err=1, discard the frame, reset count to 0, go to LOAD_A, no valid_out.
REQ-026 SHALL, on accepting element 2*N*N-1 with s_last=0 (missing last), set err=1, discard the frame, go to FLUSH.
REQ-027 SHALL in FLUSH accept and drop beats until a beat with s_last=1, then reset count to 0 and go to LOAD_A.
REQ-028 SHALL keep err set until rst; err never self-clears.
REQ-029 SHALL store s_data bit-exact; no sign extension, saturation or arithmetic.

Reset
REQ-030 SHALL on rst=1 at posedge (regardless of cen) set state LOAD_A, count 0, valid_out 0, err 0, frame_cnt 0, matrix_1/matrix_2 and shadow buffer all 0.
REQ-031 SHALL hold s_ready=0 while rst=1.
REQ-032 SHALL discard any partial frame when rst asserts mid-frame; the next accepted beat after rst is element 0.

Verification (N=2, W_IN=8)
REQ-033 Basic: cen=1, stream 1,2,3,4,5,6,7,8 with s_last on 8 -> one cycle after beat 8 valid_out=1 one cycle, matrix_1={{1,2},{3,4}}, matrix_2={{5,6},{7,8}}, frame_cnt=1, err=0.
REQ-034 Back-to-back: two frames, 16 consecutive beats, second frame -1..-8 -> two valid_out pulses 8 cycles apart, s_ready never low, final matrix_1={{-1,-2},{-3,-4}}, frame_cnt=2.
REQ-035 cen stall: deassert cen for 3 cycles after beat 5 while s_valid=1 -> s_ready=0 during the stall, no beat lost or duplicated, output identical to REQ-033.
REQ-036 Early last: s_last on beat 3, then a valid frame 9..16 -> err=1, no valid_out for the bad frame, matrices stay at prior values, then matrix_1={{9,10},{11,12}}, frame_cnt increments by 1.
REQ-037 Missing last: 10 beats with s_last only on beat 10, then a valid frame -> err=1, beats 1..10 dropped, exactly one valid_out for the following frame with correct contents.
REQ-038 Reset mid-frame: rst after beat 4 of a frame, then a full frame 1..8 -> all outputs 0 during reset, then single valid_out with REQ-033 contents, frame_cnt=1.
